// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline control: jump encodings,
// MDU sequencer states, the ID/EX bubble bundle and the hazard register compare.
package cpu_pkg;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } mdu_state_t;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic mdu;
    } ex_ctrl_t;

    localparam ex_ctrl_t NOP_CTRL = '0;

    // $0 is hardwired to zero, so it can never carry a true dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/E/M hazard inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       i_addr_Drs;
    logic [4:0]       i_addr_Drt;
    logic             i_con_Duses_rs;
    logic             i_con_Duses_rt;
    logic             i_con_Dbranch;
    logic [1:0]       i_con_Djump;
    logic             i_con_ifbranch;
    logic             i_con_Dmdu;
    logic             i_con_Dmdrd;
    logic [4:0]       i_addr_Erd;
    logic             i_con_Eregwrite;
    logic             i_con_Ememread;
    logic [4:0]       i_addr_Mrd;
    logic             i_con_Mregwrite;
    logic             o_con_Fstall;
    logic             o_con_Dstall;
    logic             o_con_Ebubble;
    logic             o_con_Dflush;
    logic             o_con_mdustart;
    logic             o_con_mdubusy;
    logic             o_con_mdudone;
    logic [CNT_W-1:0] o_cnt_stall;

    modport master (
        output i_addr_Drs, i_addr_Drt, i_con_Duses_rs, i_con_Duses_rt, i_con_Dbranch,
               i_con_Djump, i_con_ifbranch, i_con_Dmdu, i_con_Dmdrd, i_addr_Erd,
               i_con_Eregwrite, i_con_Ememread, i_addr_Mrd, i_con_Mregwrite,
        input  o_con_Fstall, o_con_Dstall, o_con_Ebubble, o_con_Dflush, o_con_mdustart,
               o_con_mdubusy, o_con_mdudone, o_cnt_stall
    );

    modport slave (
        input  i_addr_Drs, i_addr_Drt, i_con_Duses_rs, i_con_Duses_rt, i_con_Dbranch,
               i_con_Djump, i_con_ifbranch, i_con_Dmdu, i_con_Dmdrd, i_addr_Erd,
               i_con_Eregwrite, i_con_Ememread, i_addr_Mrd, i_con_Mregwrite,
        output o_con_Fstall, o_con_Dstall, o_con_Ebubble, o_con_Dflush, o_con_mdustart,
               o_con_mdubusy, o_con_mdudone, o_cnt_stall
    );

endinterface

// File: rtl/hazard_mdu_seq.sv
// Multiply/divide sequencer: tracks an MDU operation from its start pulse to the
// registered done pulse, MDU_CYCLES-1 edges later.
module hazard_mdu_seq
    import cpu_pkg::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(MDU_CYCLES);

    mdu_state_t    state;
    logic [CW-1:0] count;

    // The start cycle already uses up one of the MDU_CYCLES, so the register
    // holds the edges still to go before done; done fires on the edge after it reads 1.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (MDU_CYCLES == 2) begin
                            done <= 1'b1;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            count <= CW'(MDU_CYCLES - 2);
                        end
                    end
                end
                BUSY: begin
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        count <= '0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode-stage stall/bubble/flush generation,
// MDU sequencing and a saturating stall-cycle counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    hazard_ctrl_if.slave  hz
);

    logic             h_lu;
    logic             h_br;
    logic             h_jr;
    logic             h_md;
    logic             stall;
    logic             redirect;
    logic             mdu_start;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] cnt_stall;

    // Loads only reach the branch comparator from M, and jr has no forwarding at all
    always_comb begin
        h_lu = hz.i_con_Ememread &&
               ((hz.i_con_Duses_rs && reg_match(hz.i_addr_Erd, hz.i_addr_Drs)) ||
                (hz.i_con_Duses_rt && reg_match(hz.i_addr_Erd, hz.i_addr_Drt)));
        h_br = hz.i_con_Dbranch && hz.i_con_Ememread &&
               (reg_match(hz.i_addr_Erd, hz.i_addr_Drs) || reg_match(hz.i_addr_Erd, hz.i_addr_Drt));
        h_jr = (hz.i_con_Djump == JMP_JR) &&
               ((hz.i_con_Eregwrite && reg_match(hz.i_addr_Erd, hz.i_addr_Drs)) ||
                (hz.i_con_Mregwrite && reg_match(hz.i_addr_Mrd, hz.i_addr_Drs)));
        h_md = mdu_busy && (hz.i_con_Dmdrd || hz.i_con_Dmdu);
        stall     = i_nrst && (h_lu || h_br || h_jr || h_md);
        redirect  = (hz.i_con_Dbranch && hz.i_con_ifbranch) ||
                    (hz.i_con_Djump == JMP_J) || (hz.i_con_Djump == JMP_JR);
        mdu_start = i_nrst && hz.i_con_Dmdu && !stall;
    end

    assign hz.o_con_Fstall   = stall;
    assign hz.o_con_Dstall   = stall;
    assign hz.o_con_Ebubble  = stall;
    assign hz.o_con_Dflush   = i_nrst && !stall && redirect && (DELAY_SLOT == 0);
    assign hz.o_con_mdustart = mdu_start;
    assign hz.o_con_mdubusy  = mdu_busy;
    assign hz.o_con_mdudone  = mdu_done;
    assign hz.o_cnt_stall    = cnt_stall;

    hazard_mdu_seq #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_seq (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .start  (mdu_start),
        .busy   (mdu_busy),
        .done   (mdu_done)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_stall <= '0;
        end else if (stall && (cnt_stall != '1)) begin
            cnt_stall <= cnt_stall + 1'b1;
        end
    end

endmodule
